// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the source side of the 4-phase req/ack CDC transfer.
//   tx_state_e         : handshake FSM state (2-bit encoding)
//   TX_SYNC_STAGES_MIN : smallest usable depth of the cdc_ack synchronizer
package cdc_handshake_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b10
  } tx_state_e;

  localparam int TX_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_1bit.sv
// Multi-flop synchronizer for one asynchronous control bit.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears the whole chain
//   d     : asynchronous input bit
//   q     : synchronized output, STAGES clk edges after d
module sync_1bit
  import cdc_handshake_tx_pkg::*;
#(
  parameter int STAGES = TX_SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the asynchronous bit through the chain; chain_r[0] may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 4-phase req/ack CDC word transfer.
// A word accepted on in_valid/in_ready is held on cdc_data while cdc_req is
// raised; the transfer completes once the synchronized acknowledge has been
// seen high and then low again, marked by a one-cycle done pulse.
// Ports:
//   clk, rst_n   : source clock, asynchronous active-low reset
//   in_valid     : source word available
//   in_ready     : block can accept a word this cycle
//   in_data      : source word
//   cdc_req      : request to destination (flop output)
//   cdc_data     : held word (flop outputs)
//   cdc_ack      : asynchronous acknowledge from destination
//   busy         : handshake in progress
//   done         : one-cycle pulse at handshake completion
//   timeout_err  : sticky watchdog flag
// Optional feature macro: CDC_TX_TIMEOUT_EN enables the watchdog counter;
// without it timeout_err is tied low.
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             cdc_req,
  output logic [WIDTH-1:0] cdc_data,
  input  logic             cdc_ack,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  tx_state_e        state_r;
  tx_state_e        state_next_s;
  logic             req_next_s;
  logic [WIDTH-1:0] data_next_s;
  logic             done_next_s;
  logic             ack_s;

  sync_1bit #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cdc_ack),
    .q    (ack_s)
  );

  // A stale acknowledge left over from a source-only reset blocks new words.
  assign in_ready = (state_r == IDLE) && !ack_s;
  assign busy     = (state_r != IDLE);

  // Next-state and next-output decode of the handshake FSM.
  always_comb begin
    state_next_s = state_r;
    req_next_s   = cdc_req;
    data_next_s  = cdc_data;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_next_s  = in_data;
          req_next_s   = 1'b1;
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_next_s   = 1'b0;
          state_next_s = DROP;
        end else begin
          state_next_s = REQ;
        end
      end
      DROP: begin
        if (!ack_s) begin
          done_next_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        req_next_s   = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops cdc_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cdc_req  <= 1'b0;
      cdc_data <= '0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cdc_req  <= req_next_s;
      cdc_data <= data_next_s;
      done     <= done_next_s;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             err_r;

  // Saturating increment of the watchdog count.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r != CNT_MAX) begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_inc_s = CNT_MAX;
    end
  end

  // Watchdog: restarts on each state change, counts while waiting on the
  // destination, and latches the error flag; the FSM itself never aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else if (state_next_s != state_r) begin
      cnt_r <= '0;
    end else if (state_r != IDLE) begin
      cnt_r <= cnt_inc_s;
      if (cnt_inc_s == CNT_MAX) begin
        err_r <= 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_err = err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;
  import cdc_handshake_tx_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
`ifdef CDC_TX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             dclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             cdc_req;
  logic [WIDTH-1:0] cdc_data;
  logic             cdc_ack;
  logic             busy;
  logic             done;
  logic             timeout_err;

  logic             auto_ack = 1'b0;
  logic             man_ack = 1'b0;
  logic             dst_ack;
  logic             req_m, req_d;

  int n_checks = 0;
  int n_pass   = 0;

  assign cdc_ack = auto_ack ? dst_ack : man_ack;

  cdc_handshake_tx #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cdc_req(cdc_req), .cdc_data(cdc_data),
    .cdc_ack(cdc_ack), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // 100 MHz-like source clock and an unrelated 37 MHz-like destination clock.
  always #50 clk = ~clk;
  initial begin
    #37;
    forever #135 dclk = ~dclk;
  end

  // Destination-side model: synchronize req, capture the word, 4-phase ack.
  logic [WIDTH-1:0] cap_q[$];
  always @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      req_m   <= 1'b0;
      req_d   <= 1'b0;
      dst_ack <= 1'b0;
    end else begin
      req_m <= cdc_req;
      req_d <= req_m;
      if (auto_ack && req_d && !dst_ack) begin
        cap_q.push_back(cdc_data);
        dst_ack <= 1'b1;
      end else if (!req_d && dst_ack) begin
        dst_ack <= 1'b0;
      end
    end
  end

  // Monitor: cdc_data may only change on an edge where a word was accepted,
  // and then it must take that word.
  logic             mon_en = 1'b0;
  logic             mon_arm = 1'b0;
  logic             prev_acc = 1'b0;
  logic [WIDTH-1:0] prev_in = '0;
  logic [WIDTH-1:0] prev_q = '0;
  int               viol_cnt = 0;
  int               done_cnt = 0;
  always @(posedge clk) begin
    mon_arm <= mon_en;
    if (mon_arm && mon_en) begin
      if (prev_acc && cdc_data !== prev_in) viol_cnt <= viol_cnt + 1;
      if (!prev_acc && cdc_data !== prev_q) viol_cnt <= viol_cnt + 1;
    end
    prev_acc <= in_valid && in_ready;
    prev_in  <= in_data;
    prev_q   <= cdc_data;
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Wait (bounded) at negedges for a signal to reach a value: 0 req, 1 done, 2 busy.
  task automatic wait_sig(input int which, input logic val, input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      case (which)
        0:       seen = (cdc_req == val);
        1:       seen = (done == val);
        default: seen = (busy == val);
      endcase
      if (seen) break;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer a word from a negedge until accepted; keeps the expected stream.
  logic [WIDTH-1:0] sent_q[$];
  task automatic send_word(input logic [WIDTH-1:0] w);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int c = 0; c < 4000; c++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    sent_q.push_back(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             a;
    logic             rdy;
    logic             req;
    logic [WIDTH-1:0] q;
    logic             bsy;
    logic             dn;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base;
    int done_base;
    int viol_base;
    int bad;

    if (SYNC < TX_SYNC_STAGES_MIN) begin
      $display("SYNC_STAGES below minimum");
      $finish;
    end

    // Single transfer, one row per clock: inputs before the edge, outputs after.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0}; // accept
    tbl[1] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0}; // valid ignored
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0}; // ack syncing
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0}; // req falls
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1}; // done
    tbl[7] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0}; // accept on done

    #1;
    check("reset_state", {60'd0, cdc_req, busy, done, timeout_err}, 64'd0);
    check("reset_data", 64'(cdc_data), 64'd0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      man_ack  = tbl[i].a;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            64'({in_ready, cdc_req, cdc_data, busy, done}),
            64'({tbl[i].rdy, tbl[i].req, tbl[i].q, tbl[i].bsy, tbl[i].dn}));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of REQ.
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_req", 64'({cdc_req, cdc_data, busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'({in_ready, busy}), 64'b10);

    // Stale acknowledge held from reset.
    @(negedge clk);
    rst_n = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (5) @(negedge clk);
    check("stale_ack_block", 64'({in_ready, cdc_req, busy}), 64'd0);
    in_valid = 1'b0;
    man_ack  = 1'b0;
    @(posedge clk);
    #1;
    check("stale_ack_1edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("stale_ack_2edge", 64'(in_ready), 64'd1);

    // Watchdog: withhold ack with TIMEOUT_CYCLES=16.
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("timeout_early", 64'({timeout_err, cdc_req}), 64'b01);
    repeat (3) @(posedge clk);
    #1;
    check("timeout_set", 64'({timeout_err, cdc_req}), 64'({TO_EN, 1'b1}));
    repeat (40) @(posedge clk);
    #1;
    check("timeout_sticky", 64'({timeout_err, cdc_req, busy}), 64'({TO_EN, 2'b11}));
    @(negedge clk);
    man_ack = 1'b1;
    wait_sig(0, 1'b0, "timeout_req_fall");
    man_ack = 1'b0;
    wait_sig(1, 1'b1, "timeout_done");
    check("timeout_after_done", 64'({timeout_err, cdc_data}), 64'({TO_EN, 8'h5A}));

    // Back-to-back then random words against the asynchronous destination model.
    do_reset();
    auto_ack = 1'b1;
    sent_q.delete();
    base      = cap_q.size();
    done_base = done_cnt;
    viol_base = viol_cnt;
    @(negedge clk);
    mon_en = 1'b1;
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h03);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(WIDTH'($urandom));
    end
    wait_sig(2, 1'b0, "stream_drain");
    repeat (4) @(negedge clk);
    mon_en = 1'b0;

    check("stream_count", 64'(cap_q.size() - base), 64'(sent_q.size()));
    if (cap_q.size() >= base + 3) begin
      check("b2b_word0", 64'(cap_q[base]),     64'h01);
      check("b2b_word1", 64'(cap_q[base + 1]), 64'h02);
      check("b2b_word2", 64'(cap_q[base + 2]), 64'h03);
    end else begin
      check("b2b_words", 64'(cap_q.size() - base), 64'd3);
    end
    bad = 0;
    for (int i = 0; i < sent_q.size(); i++) begin
      if (base + i >= cap_q.size() || cap_q[base + i] !== sent_q[i]) bad++;
    end
    check("stream_data", 64'(bad), 64'd0);
    check("stream_done_pulses", 64'(done_cnt - done_base), 64'(sent_q.size()));
    check("data_stability", 64'(viol_cnt - viol_base), 64'd0);
    check("stream_timeout_err", 64'(timeout_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
